// File: rtl/borrow_lookahead_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : borrow_lookahead_subtractor_if
// Description : Operand/result stream bundle for borrow_lookahead_subtractor.
//               Input stream : in_valid, in_ready, a, b, bin
//               Output stream: out_valid, out_ready, diff, bout, ovf, zero
//               slave  modport - the subtractor itself
//               master modport - the operand producer / result consumer
// Parameters  : WIDTH - operand/result width, must match the subtractor
// Revision    : 1.0 - initial release
// ============================================================================
interface borrow_lookahead_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/borrow_lookahead_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : borrow_lookahead_subtractor
// Description : Two-stage pipelined D = A - B - Bin with group borrow
//               look-ahead, behind a valid/ready stream handshake.
//               S1 registers per-bit generate/propagate/half-difference and
//               per-group G/P; S2 resolves group borrows in look-ahead form,
//               ripples bit borrows inside each group and registers the
//               result. Latency 2, throughput 1/cycle, occupancy <= 2.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - slave modport of borrow_lookahead_subtractor_if
//                       (in_valid/in_ready/a/b/bin,
//                        out_valid/out_ready/diff/bout/ovf/zero)
// Parameters  : WIDTH (>= 2), GROUP (WIDTH % GROUP == 0)
// Build macro : SUB_SAT_EN - when defined, unsigned saturation: a borrowing
//               result is forced to 0 (zero=1); bout/ovf still reported.
// Revision    : 1.0 - initial release
// ============================================================================
module borrow_lookahead_subtractor #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input wire                           clk,
    input wire                           rst_n,
    borrow_lookahead_subtractor_if.slave bus
);
    localparam int NGRP = WIDTH / GROUP;
    localparam int MSB  = WIDTH - 1;

    // Handshake state
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s1_adv, s2_adv;

    // Stage 1 registers
    logic [WIDTH-1:0] g_q, g_d, p_q, p_d, x_q, x_d;
    logic             bin_q, bin_d;
    logic [NGRP-1:0]  gg_q, gg_d, gp_q, gp_d;

    // Stage 1 combinational values
    logic [WIDTH-1:0] w_g, w_p, w_x;
    logic [NGRP-1:0]  w_gg, w_gp;

    // Stage 2 combinational values
    logic [NGRP:0]    w_gb;
    logic             w_term, w_pchain, w_brw;
    logic [WIDTH-1:0] w_raw, w_res;
    logic             w_bout, w_ovf, w_zero;

    // Stage 2 (output) registers
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

    // ------------------------------------------------------------------
    // Handshake: each stage moves when its successor can take its content.
    // in_ready depends combinationally on out_ready through s2_adv.
    // ------------------------------------------------------------------
    always_comb begin
        s2_adv     = ~s2_valid_q | bus.out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;
        s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q   : s2_valid_q;
    end

    // ------------------------------------------------------------------
    // Stage 1: bit generate/propagate and group G/P.
    // Group G is the borrow out of the group assuming no borrow in;
    // group P says a borrow in passes straight through the group.
    // ------------------------------------------------------------------
    always_comb begin
        w_g  = ~bus.a & bus.b;
        w_p  = ~(bus.a ^ bus.b);
        w_x  = bus.a ^ bus.b;
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_gg[k] = 1'b0;
            w_gp[k] = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                w_gg[k] = w_g[k*GROUP+j] | (w_p[k*GROUP+j] & w_gg[k]);
                w_gp[k] = w_gp[k] & w_p[k*GROUP+j];
            end
        end

        g_d   = s1_adv ? w_g     : g_q;
        p_d   = s1_adv ? w_p     : p_q;
        x_d   = s1_adv ? w_x     : x_q;
        bin_d = s1_adv ? bus.bin : bin_q;
        gg_d  = s1_adv ? w_gg    : gg_q;
        gp_d  = s1_adv ? w_gp    : gp_q;
    end

    // ------------------------------------------------------------------
    // Stage 2: group borrows in flattened look-ahead form,
    //   gb[k+1] = OR_j ( G_j & P_{j+1..k} ) | ( bin & P_{0..k} ),
    // so no group waits on its neighbour; bits then ripple locally.
    // ------------------------------------------------------------------
    always_comb begin
        w_gb     = '0;
        w_term   = 1'b0;
        w_pchain = 1'b0;
        w_brw    = 1'b0;
        w_raw    = '0;

        w_gb[0] = bin_q;
        for (int k = 0; k < NGRP; k++) begin
            w_pchain = bin_q;
            for (int j = 0; j <= k; j++) begin
                w_pchain = w_pchain & gp_q[j];
            end
            w_gb[k+1] = w_pchain;
            for (int j = 0; j <= k; j++) begin
                w_term = gg_q[j];
                for (int m = j + 1; m <= k; m++) begin
                    w_term = w_term & gp_q[m];
                end
                w_gb[k+1] = w_gb[k+1] | w_term;
            end
        end

        for (int k = 0; k < NGRP; k++) begin
            w_brw = w_gb[k];
            for (int j = 0; j < GROUP; j++) begin
                w_raw[k*GROUP+j] = x_q[k*GROUP+j] ^ w_brw;
                w_brw            = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & w_brw);
            end
        end

        w_bout = w_gb[NGRP];
        // Overflow needs a[MSB] != b[MSB] (x=1); in that case a[MSB] = ~g[MSB],
        // so a[MSB] is recovered without registering the operand itself.
        w_ovf  = x_q[MSB] & (w_raw[MSB] ^ ~g_q[MSB]);

`ifdef SUB_SAT_EN
        w_res  = w_bout ? '0 : w_raw;
`else
        w_res  = w_raw;
`endif
        w_zero = (w_res == '0);

        diff_d = s2_adv ? w_res  : diff_q;
        bout_d = s2_adv ? w_bout : bout_q;
        ovf_d  = s2_adv ? w_ovf  : ovf_q;
        zero_d = s2_adv ? w_zero : zero_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            g_q        <= '0;
            p_q        <= '0;
            x_q        <= '0;
            bin_q      <= 1'b0;
            gg_q       <= '0;
            gp_q       <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            g_q        <= g_d;
            p_q        <= p_d;
            x_q        <= x_d;
            bin_q      <= bin_d;
            gg_q       <= gg_d;
            gp_q       <= gp_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_borrow_lookahead_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_borrow_lookahead_subtractor
// Description : Self-checking bench. An 8-bit instance runs a directed
//               vector table, a stall/back-pressure sequence and a
//               mid-flight reset; a 16-bit instance runs a randomized sweep
//               with random stalls against an arithmetic reference model.
// Build macro : SUB_SAT_EN - expectations follow the saturating build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_borrow_lookahead_subtractor;

`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NOPS = 10000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
    } op_t;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    borrow_lookahead_subtractor_if #(.WIDTH(8))  if8  ();
    borrow_lookahead_subtractor_if #(.WIDTH(16)) if16 ();

    borrow_lookahead_subtractor #(.WIDTH(8), .GROUP(4)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    borrow_lookahead_subtractor #(.WIDTH(16), .GROUP(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input int w, input logic [15:0] a,
                                   input logic [15:0] b, input logic bi);
        res_t        r;
        int          d;
        int          m;
        logic [15:0] raw;
        m      = (1 << w) - 1;
        d      = int'(a) - int'(b) - int'(bi);
        r.bout = (d < 0);
        raw    = 16'(d & m);
        r.ovf  = (a[w-1] != b[w-1]) && (raw[w-1] != a[w-1]);
        r.diff = (SAT && r.bout) ? 16'h0000 : raw;
        r.zero = (r.diff == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- 8-bit cycle driver with scoreboard ----------------
    op_t        q8[$];
    logic       hold8;
    logic [7:0] pdiff8;
    logic       pbout8, povf8, pzero8;

    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic bi, input logic ordy,
                         output logic acc, output logic pop);
        op_t  o;
        res_t e;
        @(negedge clk);
        if8.in_valid  = v;
        if8.a         = a;
        if8.b         = b;
        if8.bin       = bi;
        if8.out_ready = ordy;
        #1;
        acc = v & if8.in_ready;
        pop = if8.out_valid & ordy;
        if (hold8)
            chk("hold8", {if8.out_valid, if8.bout, if8.ovf, if8.zero, if8.diff},
                         {1'b1, pbout8, povf8, pzero8, pdiff8});
        if (acc) q8.push_back('{a: {8'h00, a}, b: {8'h00, b}, bin: bi});
        if (pop) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res8_extra: got diff %0h expected no result", if8.diff);
            end else begin
                o = q8.pop_front();
                e = model(8, o.a, o.b, o.bin);
                chk("res8", {if8.bout, if8.ovf, if8.zero, 8'h00, if8.diff},
                            {e.bout, e.ovf, e.zero, e.diff});
            end
        end
        hold8  = if8.out_valid & ~ordy;
        pdiff8 = if8.diff;
        pbout8 = if8.bout;
        povf8  = if8.ovf;
        pzero8 = if8.zero;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output int lat);
        logic acc, pop;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 10) begin
            step8(1'b1, a, b, bi, 1'b1, acc, pop);
            tries++;
        end
        lat = 0;
        pop = 1'b0;
        while (!pop && lat < 10) begin
            step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, pop);
            lat++;
        end
    endtask

    // ---------------- 16-bit sweep state ----------------
    op_t         q16[$];
    logic        hold16;
    logic [15:0] pdiff16;
    logic        pbout16, povf16, pzero16;

    initial begin
        vec_t       vecs[7];
        int         lat;
        logic       acc, pop;
        logic [7:0] acc_mask, pop_mask;
        op_t        o;
        res_t       e;
        int         sent, recv, cyc, n;
        logic [7:0] sa[4], sb[4];

        errors = 0;
        checks = 0;
        hold8  = 1'b0;
        hold16 = 1'b0;
        pdiff8 = '0; pbout8 = 0; povf8 = 0; pzero8 = 0;
        pdiff16 = '0; pbout16 = 0; povf16 = 0; pzero16 = 0;

        vecs[0] = '{8'h4D, 8'h2B, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0, SAT};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0, SAT};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, SAT ? 8'h00 : 8'h80, 1'b1, 1'b1, SAT};
        vecs[6] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.bin = 1'b0;  if8.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0; if16.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, if8.in_ready},  32'd1);
        chk("rst_data", {if8.bout, if8.ovf, if8.zero, if8.diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, one op at a time, latency and values
        for (int i = 0; i < 7; i++) begin
            issue8(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("lat_vec%0d", i), lat, 2);
            chk($sformatf("val_vec%0d", i),
                {if8.bout, if8.ovf, if8.zero, if8.diff},
                {vecs[i].bout, vecs[i].ovf, vecs[i].zero, vecs[i].diff});
        end

        // Back-to-back 4 ops, out_ready low for 3 cycles
        sa = '{8'h31, 8'h52, 8'h03, 8'hA4};
        sb = '{8'h11, 8'h62, 8'h05, 8'h24};
        n = 0;
        acc_mask = '0;
        pop_mask = '0;
        for (int i = 0; i < 8; i++) begin
            step8(n < 4, (n < 4) ? sa[n] : 8'h00, (n < 4) ? sb[n] : 8'h00, 1'b0,
                  i >= 3, acc, pop);
            if (i == 2) begin
                chk("full_in_ready",  {31'd0, if8.in_ready},  32'd0);
                chk("full_out_valid", {31'd0, if8.out_valid}, 32'd1);
            end
            acc_mask[i] = acc;
            pop_mask[i] = pop;
            if (acc) n++;
        end
        chk("stall_accepts", {24'd0, acc_mask}, 32'b0001_1011);
        chk("stall_pops",    {24'd0, pop_mask}, 32'b0111_1000);

        // Reset with two ops in flight
        step8(1'b1, 8'h11, 8'h01, 1'b0, 1'b0, acc, pop);
        chk("rstseq_acc0", {31'd0, acc}, 32'd1);
        step8(1'b1, 8'h22, 8'h02, 1'b0, 1'b0, acc, pop);
        chk("rstseq_acc1", {31'd0, acc}, 32'd1);
        @(negedge clk);
        if8.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", {31'd0, if8.out_valid}, 32'd0);
        chk("rstmid_in_ready",  {31'd0, if8.in_ready},  32'd1);
        chk("rstmid_data", {if8.bout, if8.ovf, if8.zero, if8.diff}, 32'd0);
        q8.delete();
        hold8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, pop);
            chk("no_stale", {31'd0, if8.out_valid}, 32'd0);
        end
        issue8(8'h30, 8'h10, 1'b0, lat);
        chk("lat_after_rst", lat, 2);
        chk("val_after_rst", {if8.bout, if8.ovf, if8.zero, if8.diff}, {3'b000, 8'h20});

        // Randomized sweep on the 16-bit instance
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < NOPS && cyc < 80000) begin
            @(negedge clk);
            if16.in_valid  = (sent < NOPS) && ($urandom_range(0, 9) < 7);
            if16.a         = 16'($urandom);
            if16.b         = ($urandom_range(0, 7) == 0) ? if16.a : 16'($urandom);
            if16.bin       = 1'($urandom);
            if16.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (hold16)
                chk("hold16", {if16.out_valid, if16.bout, if16.ovf, if16.zero, if16.diff},
                              {1'b1, pbout16, povf16, pzero16, pdiff16});
            if (if16.in_valid && if16.in_ready) begin
                q16.push_back('{a: if16.a, b: if16.b, bin: if16.bin});
                sent++;
            end
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res16_extra: got diff %0h expected no result", if16.diff);
                end else begin
                    o = q16.pop_front();
                    e = model(16, o.a, o.b, o.bin);
                    chk("res16", {if16.bout, if16.ovf, if16.zero, if16.diff},
                                 {e.bout, e.ovf, e.zero, e.diff});
                end
                recv++;
            end
            hold16  = if16.out_valid & ~if16.out_ready;
            pdiff16 = if16.diff;
            pbout16 = if16.bout;
            povf16  = if16.ovf;
            pzero16 = if16.zero;
            cyc++;
        end
        chk("sweep_done", recv, NOPS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
